dram_timing_seq: RTL and testbench

//  Parametrised DRAM RAS/CAS sequencer for the system-board RAM banks; replaces the fixed tap-delay RAS->addr_sel->CAS chain.

---
 rtl/dram_timing_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_dram_timing_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_timing_seq.sv
// dram_timing_seq: RAS/CAS sequencer for the system-board DRAM banks.
// Runs one access (RAS -> addr_sel -> CAS -> precharge) at a time with
// programmable phase lengths, and interleaves RAS-only refresh cycles
// driven by a free-running refresh timer and a small backlog counter.
module dram_timing_seq #(
  parameter int BANKS      = 4,
  parameter int BANK_BITS  = 2,
  parameter int ROW_BITS   = 8,
  parameter int RCD        = 3,
  parameter int A2C        = 2,
  parameter int CAS_W      = 5,
  parameter int PRE        = 4,
  parameter int REF_PERIOD = 1500,
  parameter int REF_W      = 8
) (
  input  logic                 clk_100,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [BANK_BITS-1:0] bank,
  output logic                 ack,
  output logic                 busy,
  output logic [BANKS-1:0]     ras_n,
  output logic [BANKS-1:0]     cas_n,
  output logic                 addr_sel,
  output logic                 dram_we_n,
  output logic                 ref_active,
  output logic [ROW_BITS-1:0]  ref_row
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The shared down-counter only has to hold the longest phase length minus one.
  localparam int MAX_D = max_of(max_of(max_of(RCD, A2C), max_of(CAS_W, PRE)), REF_W);
  localparam int CNT_W = (MAX_D > 1) ? $clog2(MAX_D) : 1;
  localparam int TMR_W = $clog2(REF_PERIOD);

  localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(RCD - 1);
  localparam logic [CNT_W-1:0] LD_A2C = CNT_W'(A2C - 1);
  localparam logic [CNT_W-1:0] LD_CAS = CNT_W'(CAS_W - 1);
  localparam logic [CNT_W-1:0] LD_PRE = CNT_W'(PRE - 1);
  localparam logic [CNT_W-1:0] LD_REF = CNT_W'(REF_W - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REF_PERIOD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAS,
    ST_ASEL,
    ST_CAS,
    ST_PRE,
    ST_REF,
    ST_REF_PRE
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [BANK_BITS-1:0] bank_reg, bank_next;
  logic                 we_reg, we_next;
  logic                 armed_reg, armed_next;
  logic [1:0]           backlog_reg, backlog_next;
  logic [TMR_W-1:0]     tmr_reg, tmr_next;
  logic [ROW_BITS-1:0]  ref_row_reg, ref_row_next;

  logic                 ack_reg, ack_next;
  logic                 busy_reg, busy_next;
  logic [BANKS-1:0]     ras_n_reg, ras_n_next;
  logic [BANKS-1:0]     cas_n_reg, cas_n_next;
  logic                 addr_sel_reg, addr_sel_next;
  logic                 dram_we_n_reg, dram_we_n_next;
  logic                 ref_active_reg, ref_active_next;

  logic                 cnt_done;
  logic                 tick;
  logic                 ref_done;
  logic                 decide;
  logic [1:0]           backlog_eff;
  logic                 start_ref;
  logic                 accept;
  logic [BANKS-1:0]     bank_hit;

  assign cnt_done = (cnt_reg == '0);
  assign tick     = (tmr_reg == TMR_LAST);
  assign ref_done = (state_reg == ST_REF_PRE) && cnt_done;

  // The last precharge cycle doubles as an idle decision point, so back-to-back
  // accesses (and an access right after a refresh) lose no extra cycle.
  assign decide = (state_reg == ST_IDLE) ||
                  ((state_reg == ST_PRE) && cnt_done) ||
                  ref_done;

  // A refresh that is just finishing no longer counts as pending.
  assign backlog_eff = backlog_reg - {1'b0, ref_done};
  assign start_ref   = decide && (backlog_eff != 2'd0);
  assign accept      = decide && (backlog_eff == 2'd0) && req && armed_reg;

  assign bank_next = accept ? bank : bank_reg;
  assign we_next   = accept ? we : we_reg;

  // Re-arm only after the requester has been seen low, so a held req is one access.
  assign armed_next = accept ? 1'b0 : (!req ? 1'b1 : armed_reg);

  assign tmr_next     = tick ? '0 : tmr_reg + 1'b1;
  assign ref_row_next = ref_done ? ref_row_reg + 1'b1 : ref_row_reg;

  // Bank select decode; an out-of-range bank matches nothing and drives no strobe.
  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank_hit
    assign bank_hit[gi] = (bank_next == BANK_BITS'(gi));
  end

  // Backlog counter: saturating increment on tick, decrement when a refresh completes.
  always_comb begin
    backlog_next = backlog_reg;
    if (tick && !ref_done) begin
      backlog_next = (backlog_reg == 2'd3) ? 2'd3 : backlog_reg + 2'd1;
    end else if (!tick && ref_done) begin
      backlog_next = backlog_reg - 2'd1;
    end
  end

  // Next state, phase counter and the registered strobe values for the next cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_done ? cnt_reg : cnt_reg - 1'b1;

    case (state_reg)
      ST_RAS:  if (cnt_done) begin state_next = ST_ASEL;    cnt_next = LD_A2C; end
      ST_ASEL: if (cnt_done) begin state_next = ST_CAS;     cnt_next = LD_CAS; end
      ST_CAS:  if (cnt_done) begin state_next = ST_PRE;     cnt_next = LD_PRE; end
      ST_REF:  if (cnt_done) begin state_next = ST_REF_PRE; cnt_next = LD_PRE; end
      default: ;
    endcase

    if (decide) begin
      if (start_ref) begin
        state_next = ST_REF;
        cnt_next   = LD_REF;
      end else if (accept) begin
        state_next = ST_RAS;
        cnt_next   = LD_RCD;
      end else begin
        state_next = ST_IDLE;
      end
    end

    ras_n_next      = '1;
    cas_n_next      = '1;
    addr_sel_next   = 1'b0;
    dram_we_n_next  = 1'b1;
    ref_active_next = 1'b0;
    busy_next       = (state_next != ST_IDLE);
    ack_next        = (state_reg == ST_CAS) && cnt_done;

    case (state_next)
      ST_RAS: begin
        ras_n_next     = ~bank_hit;
        dram_we_n_next = ~we_next;
      end
      ST_ASEL: begin
        ras_n_next     = ~bank_hit;
        addr_sel_next  = 1'b1;
        dram_we_n_next = ~we_next;
      end
      ST_CAS: begin
        ras_n_next     = ~bank_hit;
        cas_n_next     = ~bank_hit;
        addr_sel_next  = 1'b1;
        dram_we_n_next = ~we_next;
      end
      ST_REF: begin
        ras_n_next      = '0;
        ref_active_next = 1'b1;
      end
      ST_REF_PRE: begin
        ref_active_next = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers; reset releases every strobe immediately.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      bank_reg       <= '0;
      we_reg         <= 1'b0;
      armed_reg      <= 1'b1;
      backlog_reg    <= 2'd0;
      tmr_reg        <= '0;
      ref_row_reg    <= '0;
      ack_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      ras_n_reg      <= '1;
      cas_n_reg      <= '1;
      addr_sel_reg   <= 1'b0;
      dram_we_n_reg  <= 1'b1;
      ref_active_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bank_reg       <= bank_next;
      we_reg         <= we_next;
      armed_reg      <= armed_next;
      backlog_reg    <= backlog_next;
      tmr_reg        <= tmr_next;
      ref_row_reg    <= ref_row_next;
      ack_reg        <= ack_next;
      busy_reg       <= busy_next;
      ras_n_reg      <= ras_n_next;
      cas_n_reg      <= cas_n_next;
      addr_sel_reg   <= addr_sel_next;
      dram_we_n_reg  <= dram_we_n_next;
      ref_active_reg <= ref_active_next;
    end
  end

  assign ack        = ack_reg;
  assign busy       = busy_reg;
  assign ras_n      = ras_n_reg;
  assign cas_n      = cas_n_reg;
  assign addr_sel   = addr_sel_reg;
  assign dram_we_n  = dram_we_n_reg;
  assign ref_active = ref_active_reg;
  assign ref_row    = ref_row_reg;

endmodule

// File: tb/tb_dram_timing_seq.sv
// tb_dram_timing_seq: randomized bench for dram_timing_seq with a timeline
// reference model (each operation is a start cycle plus fixed offsets) feeding
// a per-cycle expectation queue and an ack scoreboard.
module tb_dram_timing_seq;

  localparam int BANKS = 3;
  localparam int BANK_BITS = 2;
  localparam int ROW_BITS = 3;
  localparam int REF_P = 1500;

  logic                 clk_100 = 1'b0;
  logic                 rst = 1'b1;
  logic                 req = 1'b0;
  logic                 we = 1'b0;
  logic [BANK_BITS-1:0] bank = '0;
  logic                 ack, busy, addr_sel, dram_we_n, ref_active;
  logic [BANKS-1:0]     ras_n, cas_n;
  logic [ROW_BITS-1:0]  ref_row;

  dram_timing_seq #(
    .BANKS(BANKS), .BANK_BITS(BANK_BITS), .ROW_BITS(ROW_BITS),
    .RCD(3), .A2C(2), .CAS_W(5), .PRE(4), .REF_PERIOD(REF_P), .REF_W(8)
  ) dut (
    .clk_100(clk_100), .reset(rst), .req(req), .we(we), .bank(bank),
    .ack(ack), .busy(busy), .ras_n(ras_n), .cas_n(cas_n), .addr_sel(addr_sel),
    .dram_we_n(dram_we_n), .ref_active(ref_active), .ref_row(ref_row)
  );

  always #5 clk_100 = ~clk_100;

  typedef struct packed {
    int   cyc;
    int   bnk;
    logic w;
  } ack_t;

  logic [14:0] exp_q[$];
  ack_t        ack_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          fail_prints = 0;
  int          n_acks = 0;

  // Reference model state: current operation as (kind, start cycle) plus bookkeeping.
  int m_kind, m_start, m_bank, m_backlog, m_row;
  bit m_we, m_armed;

  function automatic logic [14:0] pack_out(input logic [2:0] r, input logic [2:0] c,
                                           input logic a, input logic w, input logic k,
                                           input logic b, input logic f, input logic [2:0] row);
    return {r, c, a, w, k, b, f, row};
  endfunction

  // Model: at each edge decide what the sequencer starts, then derive outputs from offsets.
  initial begin
    forever begin
      @(posedge clk_100);
      if (rst) begin
        cyc = 0; m_kind = 0; m_start = 0; m_bank = 0; m_we = 0;
        m_backlog = 0; m_row = 0; m_armed = 1;
      end else begin
        int d, eff;
        bit tick, done_ref, decide, accepted;
        logic [2:0] r, c;
        logic a, w, k, b, f;
        cyc++;
        tick = (cyc % REF_P) == 0;
        done_ref = (m_kind == 2) && (cyc - m_start == 12);
        decide = (m_kind == 0) || ((m_kind == 1) && (cyc - m_start == 14)) || done_ref;
        if (done_ref) m_row = (m_row + 1) % 8;
        eff = m_backlog - (done_ref ? 1 : 0);
        accepted = 0;
        if (decide) begin
          if (eff > 0) begin
            m_kind = 2; m_start = cyc;
          end else if (req && m_armed) begin
            m_kind = 1; m_start = cyc; m_bank = int'(bank); m_we = we; accepted = 1;
            ack_q.push_back('{cyc: cyc + 10, bnk: m_bank, w: m_we});
          end else begin
            m_kind = 0;
          end
        end
        if (accepted) m_armed = 0;
        else if (!req) m_armed = 1;
        m_backlog = eff + (tick ? 1 : 0);
        if (m_backlog > 3) m_backlog = 3;

        d = cyc - m_start;
        r = 3'b111; c = 3'b111; a = 0; w = 1; k = 0; b = 0; f = 0;
        if (m_kind == 1) begin
          b = 1;
          if (d < 10 && m_bank < BANKS) r[m_bank] = 1'b0;
          if (d >= 5 && d < 10 && m_bank < BANKS) c[m_bank] = 1'b0;
          a = (d >= 3) && (d < 10);
          if (d < 10) w = ~m_we;
          k = (d == 10);
        end else if (m_kind == 2) begin
          b = 1; f = 1;
          if (d < 8) r = 3'b000;
        end
        exp_q.push_back(pack_out(r, c, a, w, k, b, f, 3'(m_row)));
      end
    end
  end

  // Monitor: compare every output cycle and score each ack against the pending queue.
  initial begin
    forever begin
      @(negedge clk_100);
      if (!rst && exp_q.size() > 0) begin
        logic [14:0] got, want;
        want = exp_q.pop_front();
        got = pack_out(ras_n, cas_n, addr_sel, dram_we_n, ack, busy, ref_active, ref_row);
        checks++;
        if (got !== want) begin
          errors++;
          if (fail_prints < 20) begin
            fail_prints++;
            $display("FAIL cycle_outputs cyc=%0d got ras=%b cas=%b asel=%b wen=%b ack=%b busy=%b ref=%b row=%0d want ras=%b cas=%b asel=%b wen=%b ack=%b busy=%b ref=%b row=%0d",
                     cyc, got[14:12], got[11:9], got[8], got[7], got[6], got[5], got[4], got[2:0],
                     want[14:12], want[11:9], want[8], want[7], want[6], want[5], want[4], want[2:0]);
          end
        end
      end
      if (!rst && ack === 1'b1) begin
        checks++;
        if (ack_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected cyc=%0d got ack=1 want no pending access", cyc);
        end else begin
          ack_t e;
          e = ack_q.pop_front();
          n_acks++;
          if (e.cyc != cyc) begin
            errors++;
            $display("FAIL ack_time got cyc=%0d want cyc=%0d bank=%0d", cyc, e.cyc, e.bnk);
          end else begin
            $display("ack %0d: cyc=%0d bank=%0d we=%0d row=%0d", n_acks, cyc, e.bnk, e.w, ref_row);
          end
        end
      end
    end
  end

  // One access: raise req, optionally wiggle bank/we until ack, hold, then drop req.
  task automatic do_access(input int b, input bit w, input int hold, input bit scramble);
    int n;
    bank = BANK_BITS'(b);
    we = w;
    req = 1'b1;
    n = 0;
    @(negedge clk_100);
    while (ack !== 1'b1 && n < 100) begin
      if (scramble && busy === 1'b1) begin
        bank = BANK_BITS'($urandom_range(0, 3));
        we = 1'($urandom_range(0, 1));
      end
      @(negedge clk_100);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL ack_timeout got no ack after %0d cycles want ack within 100", n);
    end
    repeat (hold) @(negedge clk_100);
    req = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state while reset is held.
    @(negedge clk_100);
    checks++;
    if ({ras_n, cas_n, addr_sel, dram_we_n, ack, busy, ref_active, ref_row} !== {3'b111, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state got ras=%b cas=%b busy=%b row=%0d want ras=111 cas=111 busy=0 row=0", ras_n, cas_n, busy, ref_row);
    end
    repeat (2) @(negedge clk_100);
    rst = 1'b0;
    repeat (3) @(negedge clk_100);

    // Start a read and hit it with reset in the middle of CAS.
    bank = 2'd2; we = 1'b0; req = 1'b1;
    n = 0;
    while (cas_n === 3'b111 && n < 50) begin @(negedge clk_100); n++; end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL cas_timeout got cas_n=%b after %0d cycles want cas low", cas_n, n);
    end
    @(negedge clk_100);
    #2;
    rst = 1'b1;
    exp_q.delete();
    ack_q.delete();
    #1;
    checks++;
    if (ras_n !== 3'b111) begin errors++; $display("FAIL midcas_ras got %b want 111", ras_n); end
    checks++;
    if (cas_n !== 3'b111) begin errors++; $display("FAIL midcas_cas got %b want 111", cas_n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midcas_busy got %b want 0", busy); end
    req = 1'b0;
    repeat (3) @(negedge clk_100);
    rst = 1'b0;
    repeat (2) @(negedge clk_100);

    // Plain read on bank 2, then a write on bank 1 with req held long after ack.
    do_access(2, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk_100);
    do_access(1, 1'b1, 30, 1'b0);
    repeat (3) @(negedge clk_100);
    // Out-of-range bank still completes.
    do_access(3, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk_100);

    // Request raised right after the first refresh tick: refresh goes first.
    while (cyc < REF_P) @(negedge clk_100);
    do_access(0, 1'b1, 0, 1'b0);
    repeat (2) @(negedge clk_100);

    // Randomized traffic long enough for the refresh row counter to wrap.
    while (cyc < 12600) begin
      int b, hold;
      bit w, scr;
      b = int'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 15) == 0) ? 30 : int'($urandom_range(0, 3));
      scr = 1'($urandom_range(0, 1));
      do_access(b, w, hold, scr);
      repeat ($urandom_range(1, 4)) @(negedge clk_100);
    end

    repeat (30) @(negedge clk_100);
    checks++;
    if (ack_q.size() != 0) begin
      errors++;
      $display("FAIL ack_missing got %0d accesses without ack want 0", ack_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
